// File: rtl/expr_arbiter.sv
// expr_arbiter: round-robin sharing of one single-digit expression checker among N_REQ streams.
// Optional COLLECT idle abort is compiled in when EXPR_ARB_TIMEOUT_EN is defined.
module expr_arbiter #(
   parameter int         N_REQ   = 2,
   parameter int         ID_W    = 1,
   parameter int         MAX_LEN = 16,
   parameter logic [7:0] TERM    = 8'h3D,
   parameter int         TIMEOUT = 32
) (
   input  logic               clk,
   input  logic               clr,
   input  logic [N_REQ-1:0]   req,
   input  logic [N_REQ-1:0]   req_valid,
   input  logic [8*N_REQ-1:0] req_data,
   output logic [N_REQ-1:0]   req_ready,
   output logic [N_REQ-1:0]   gnt,
   output logic               chk_clr,
   output logic [7:0]         chk_in,
   input  logic               chk_out,
   output logic               done,
   output logic               result,
   output logic               err,
   output logic [ID_W-1:0]    resp_id
);
   localparam int LEN_W = $clog2(MAX_LEN + 1);
   localparam int AW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

   generate
      if (ID_W < $clog2(N_REQ) || MAX_LEN < 1 || TIMEOUT < 1) begin : g_bad_cfg
         $error("expr_arbiter: inconsistent parameters");
      end
   endgenerate

   // states: IDLE arbitrate | COLLECT buffer line | CLEAR clear checker | PLAY replay | RESULT sample verdict
   typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_CLEAR, S_PLAY, S_RESULT} state_t;

   state_t           state_q, state_d;
   logic [ID_W-1:0]  rr_q, rr_d, gid_q, gid_d, pick;
   logic             found;
   logic [LEN_W-1:0] len_q, len_d, idx_q, idx_d;
   logic             ovf_q, ovf_d, skip_q, skip_d, wr_en;
   logic [7:0]       buf_q [MAX_LEN];
   logic [7:0]       char_in;
   logic [N_REQ-1:0] gnt_q, gnt_d, ready_q, ready_d;
   logic             chk_clr_q, chk_clr_d, done_q, done_d;
   logic             result_q, result_d, err_q, err_d;
   logic [7:0]       chk_in_q, chk_in_d;
   logic [ID_W-1:0]  resp_id_q, resp_id_d;

`ifdef EXPR_ARB_TIMEOUT_EN
   localparam int               TMR_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 1);
   logic [TMR_W-1:0] tmr_q, tmr_d;

   always_ff @(posedge clk or posedge clr) begin
      if (clr) tmr_q <= '0;
      else     tmr_q <= tmr_d;
   end
`endif

   assign char_in = req_data[8*int'(gid_q) +: 8];

   always_comb begin
      found = 1'b0;
      pick  = rr_q;
      for (int o = 0; o < N_REQ; o++) begin
         if (!found && req[(int'(rr_q) + o) % N_REQ]) begin
            found = 1'b1;
            pick  = ID_W'((int'(rr_q) + o) % N_REQ);
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      rr_d      = rr_q;
      gid_d     = gid_q;
      len_d     = len_q;
      idx_d     = idx_q;
      ovf_d     = ovf_q;
      skip_d    = skip_q;
      wr_en     = 1'b0;
      chk_clr_d = 1'b0;
      chk_in_d  = 8'h00;
      done_d    = 1'b0;
      result_d  = 1'b0;
      err_d     = 1'b0;
      resp_id_d = '0;
`ifdef EXPR_ARB_TIMEOUT_EN
      tmr_d     = tmr_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (found) begin
               state_d = S_COLLECT;
               gid_d   = pick;
               len_d   = '0;
               ovf_d   = 1'b0;
               skip_d  = 1'b0;
`ifdef EXPR_ARB_TIMEOUT_EN
               tmr_d   = TMR_LOAD;
`endif
            end
         end
         S_COLLECT: begin
            if (req_valid[gid_q]) begin
`ifdef EXPR_ARB_TIMEOUT_EN
               tmr_d = TMR_LOAD;
`endif
               if (char_in == TERM) begin
                  // empty or overflowed lines bypass the checker entirely
                  if (len_q != '0 && !ovf_q) begin
                     state_d   = S_CLEAR;
                     chk_clr_d = 1'b1;
                  end else begin
                     state_d = S_RESULT;
                     skip_d  = 1'b1;
                  end
               end else if (len_q == LEN_W'(MAX_LEN)) begin
                  ovf_d = 1'b1;
               end else begin
                  wr_en = 1'b1;
                  len_d = len_q + LEN_W'(1);
               end
            end
`ifdef EXPR_ARB_TIMEOUT_EN
            else if (tmr_q == '0) begin
               state_d = S_RESULT;
               skip_d  = 1'b1;
               ovf_d   = 1'b1;
            end else begin
               tmr_d = tmr_q - TMR_W'(1);
            end
`endif
         end
         S_CLEAR: begin
            state_d  = S_PLAY;
            chk_in_d = buf_q[0];
            idx_d    = LEN_W'(1);
         end
         S_PLAY: begin
            if (idx_q == len_q) begin
               state_d = S_RESULT;
            end else begin
               chk_in_d = buf_q[idx_q[AW-1:0]];
               idx_d    = idx_q + LEN_W'(1);
            end
         end
         S_RESULT: begin
            state_d   = S_IDLE;
            done_d    = 1'b1;
            result_d  = chk_out & ~skip_q;
            err_d     = ovf_q;
            resp_id_d = gid_q;
            rr_d      = ID_W'((int'(gid_q) + 1) % N_REQ);
         end
         default: state_d = S_IDLE;
      endcase
      gnt_d   = (state_d != S_IDLE)    ? (N_REQ'(1) << gid_d) : '0;
      ready_d = (state_d == S_COLLECT) ? (N_REQ'(1) << gid_d) : '0;
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q   <= S_IDLE;
         rr_q      <= '0;
         gid_q     <= '0;
         len_q     <= '0;
         idx_q     <= '0;
         ovf_q     <= 1'b0;
         skip_q    <= 1'b0;
         gnt_q     <= '0;
         ready_q   <= '0;
         chk_clr_q <= 1'b0;
         chk_in_q  <= 8'h00;
         done_q    <= 1'b0;
         result_q  <= 1'b0;
         err_q     <= 1'b0;
         resp_id_q <= '0;
      end else begin
         state_q   <= state_d;
         rr_q      <= rr_d;
         gid_q     <= gid_d;
         len_q     <= len_d;
         idx_q     <= idx_d;
         ovf_q     <= ovf_d;
         skip_q    <= skip_d;
         gnt_q     <= gnt_d;
         ready_q   <= ready_d;
         chk_clr_q <= chk_clr_d;
         chk_in_q  <= chk_in_d;
         done_q    <= done_d;
         result_q  <= result_d;
         err_q     <= err_d;
         resp_id_q <= resp_id_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) buf_q[len_q[AW-1:0]] <= char_in;
   end

   assign gnt       = gnt_q;
   assign req_ready = ready_q;
   assign chk_clr   = chk_clr_q;
   assign chk_in    = chk_in_q;
   assign done      = done_q;
   assign result    = result_q;
   assign err       = err_q;
   assign resp_id   = resp_id_q;
endmodule

// File: tb/tb_expr_arbiter.sv
// Bench for expr_arbiter: directed cases plus random traffic, with a stand-in checker
// and a line-level reference model. Timeout case runs when EXPR_ARB_TIMEOUT_EN is defined.
module tb_expr_arbiter;
   localparam int         N       = 2;
   localparam int         ID_W    = 1;
   localparam int         MAX_LEN = 4;
   localparam int         TIMEOUT = 8;
   localparam logic [7:0] TERM    = 8'h3D;

   logic             clk = 1'b0;
   logic             clr;
   logic [N-1:0]     req, req_valid, req_ready, gnt;
   logic [8*N-1:0]   req_data;
   logic             chk_clr, done, result, err;
   logic             chk_out = 1'b0;
   logic [7:0]       chk_in;
   logic [ID_W-1:0]  resp_id;

   expr_arbiter #(.N_REQ(N), .ID_W(ID_W), .MAX_LEN(MAX_LEN), .TERM(TERM), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .clr(clr), .req(req), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .gnt(gnt), .chk_clr(chk_clr), .chk_in(chk_in), .chk_out(chk_out),
      .done(done), .result(result), .err(err), .resp_id(resp_id));

   always #5 clk = ~clk;

   function automatic bit is_dig(logic [7:0] c);
      return c >= 8'h30 && c <= 8'h39;
   endfunction

   function automatic bit is_op(logic [7:0] c);
      return c == 8'h2B || c == 8'h2D || c == 8'h2A || c == 8'h2F;
   endfunction

   // stand-in checker: registered verdict, one char per clock
   logic ck_exp_dig = 1'b1, ck_bad = 1'b0;
   always @(posedge clk) begin
      if (chk_clr) begin
         ck_exp_dig <= 1'b1; ck_bad <= 1'b0; chk_out <= 1'b0;
      end else if (ck_exp_dig) begin
         if (is_dig(chk_in)) begin ck_exp_dig <= 1'b0; chk_out <= !ck_bad; end
         else begin ck_bad <= 1'b1; chk_out <= 1'b0; end
      end else begin
         if (is_op(chk_in)) ck_exp_dig <= 1'b1; else ck_bad <= 1'b1;
         chk_out <= 1'b0;
      end
   end

   int n_tests = 0, n_fail = 0;

   task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   typedef struct {
      int    id;
      string s;
      bit    res;
      bit    er;
      bit    clean;
   } exp_t;

   // a line is valid when it reads digit (op digit)*
   function automatic bit expr_ok(string s);
      if (s.len() % 2 == 0) return 1'b0;
      for (int i = 0; i < s.len(); i++)
         if ((i % 2 == 0) ? !is_dig(s[i]) : !is_op(s[i])) return 1'b0;
      return 1'b1;
   endfunction

   function automatic exp_t mk_exp(int id, string s, bit timed_out);
      exp_t e;
      e.id = id; e.s = s;
      if (timed_out || s.len() > MAX_LEN) begin e.res = 0; e.er = 1; e.clean = 0; end
      else if (s.len() == 0)              begin e.res = 0; e.er = 0; e.clean = 0; end
      else                                begin e.res = expr_ok(s); e.er = 0; e.clean = 1; end
      return e;
   endfunction

   function automatic byte op_char(int unsigned i);
      case (i)
         0: return 8'h2B;
         1: return 8'h2D;
         2: return 8'h2A;
         default: return 8'h2F;
      endcase
   endfunction

   function automatic string rand_str();
      string       s = "";
      int unsigned len = $urandom_range(6);
      bit          good = ($urandom_range(3) != 0);
      byte         c;
      for (int i = 0; i < int'(len); i++) begin
         if (good && i % 2 == 0) c = byte'(8'h30 + $urandom_range(9));
         else if (good) c = op_char($urandom_range(3));
         else begin
            case ($urandom_range(2))
               0: c = byte'(8'h30 + $urandom_range(9));
               1: c = op_char($urandom_range(3));
               default: c = 8'h61;
            endcase
         end
         s = $sformatf("%s%c", s, c);
      end
      return s;
   endfunction

   string        jobs [N][$];
   exp_t         exp_q[$];
   int           pos  [N];
   int           gaps [N];
   int           rr_m, clr_cnt;
   bit           collecting;
   byte          play_q[$];
   logic [N-1:0] gnt_prev, last_gnt;

   task automatic model_reset();
      for (int k = 0; k < N; k++) begin
         jobs[k].delete(); pos[k] = 0; gaps[k] = 0;
      end
      exp_q.delete(); play_q.delete();
      rr_m = 0; clr_cnt = 0; collecting = 0; gnt_prev = '0; last_gnt = '0;
   endtask

   task automatic step();
      int          w;
      exp_t        e;
      logic [63:0] got_s, exp_s;
      string       s;
      @(negedge clk);
      if (gnt != '0 && gnt_prev == '0) begin
         w = -1;
         for (int o = 0; o < N; o++)
            if (w < 0 && req[(rr_m + o) % N]) w = (rr_m + o) % N;
         check_eq("gnt_winner", 64'(gnt), (w < 0) ? 64'd0 : (64'd1 << w));
      end else if (gnt != '0 && gnt != gnt_prev) begin
         check_eq("gnt_overlap", 64'(gnt_prev), 64'd0);
      end
      if (req_ready != '0) check_eq("ready_outside_gnt", 64'(req_ready & ~gnt), 64'd0);
      if (gnt != '0) last_gnt = gnt;
      if (chk_clr) begin
         clr_cnt++; collecting = 1; play_q.delete();
      end else if (collecting && !done) begin
         play_q.push_back(byte'(chk_in));
      end
      if (done) begin
         if (exp_q.size() == 0) begin
            check_eq("done_unexpected", 64'(done), 64'd0);
         end else begin
            e = exp_q.pop_front();
            check_eq("resp_id", 64'(resp_id), 64'(e.id));
            check_eq("result", 64'(result), 64'(e.res));
            check_eq("err", 64'(err), 64'(e.er));
            check_eq("gnt_held", 64'(last_gnt), 64'd1 << e.id);
            check_eq("gnt_dropped", 64'(gnt), 64'd0);
            check_eq("chk_clr_pulses", 64'(clr_cnt), 64'(e.clean));
            if (e.clean) begin
               // CLEAR, L PLAY cycles, RESULT (chk_in 0), then done
               check_eq("play_latency", 64'(play_q.size()), 64'(e.s.len() + 1));
               got_s = '0; exp_s = '0;
               foreach (play_q[i]) got_s = {got_s[55:0], play_q[i]};
               for (int i = 0; i < e.s.len(); i++) exp_s = {exp_s[55:0], e.s[i]};
               exp_s = {exp_s[55:0], 8'h00};
               check_eq("play_chars", got_s, exp_s);
            end
            rr_m = (e.id + 1) % N;
         end
         clr_cnt = 0; collecting = 0; play_q.delete();
      end
      for (int k = 0; k < N; k++) begin
         req_valid[k] = 1'b0;
         if (req_ready[k] && jobs[k].size() > 0) begin
            s = jobs[k][0];
            if (pos[k] < s.len() && s[pos[k]] == 8'h21) begin
               exp_q.push_back(mk_exp(k, s.substr(0, pos[k] - 1), 1'b1));
               void'(jobs[k].pop_front()); pos[k] = 0;
            end else if (gaps[k] < 3 && $urandom_range(3) == 0) begin
               gaps[k]++;
            end else begin
               gaps[k] = 0;
               req_valid[k] = 1'b1;
               req_data[8*k +: 8] = (pos[k] < s.len()) ? s[pos[k]] : TERM;
               if (pos[k] == s.len()) begin
                  exp_q.push_back(mk_exp(k, s, 1'b0));
                  void'(jobs[k].pop_front()); pos[k] = 0;
               end else begin
                  pos[k]++;
               end
            end
         end
         req[k] = (jobs[k].size() > 0) && (!gnt[k] || $urandom_range(1) == 1);
      end
      gnt_prev = gnt;
   endtask

   function automatic bit all_idle();
      for (int k = 0; k < N; k++) if (jobs[k].size() > 0) return 1'b0;
      return exp_q.size() == 0 && gnt == '0;
   endfunction

   task automatic run(int budget, bit stop_on_play, string tag);
      int c = 0;
      forever begin
         step();
         c++;
         if (stop_on_play && chk_in != 8'h00) return;
         if (!stop_on_play && all_idle()) return;
         if (c >= budget) begin
            check_eq({tag, "_cycle_budget"}, 64'd1, 64'd0);
            return;
         end
      end
   endtask

   initial begin
      clr = 1'b1; req = '0; req_valid = '0; req_data = '0;
      model_reset();
      #12;
      check_eq("reset_outputs",
               64'({gnt, req_ready, chk_clr, chk_in, done, result, err, resp_id}), 64'd0);
      @(negedge clk);
      clr = 1'b0;

      jobs[0].push_back("1+2");                               run(200, 1'b0, "t1");
      jobs[1].push_back("12");                                run(200, 1'b0, "t2");
      jobs[0].push_back("3*4"); jobs[1].push_back("3*4");     run(400, 1'b0, "t3");
      jobs[0].push_back("1+2+3");                             run(200, 1'b0, "t4");
      jobs[0].push_back("");                                  run(200, 1'b0, "t5");

      jobs[0].push_back("9-8");
      run(200, 1'b1, "t6_play");
      clr = 1'b1;
      #1;
      check_eq("async_clear",
               64'({gnt, req_ready, chk_clr, chk_in, done, result, err, resp_id}), 64'd0);
      model_reset();
      req = '0; req_valid = '0;
      @(negedge clk);
      clr = 1'b0;
      jobs[1].push_back("5-6");                               run(200, 1'b0, "t6");

      for (int r = 0; r < 40; r++) begin
         for (int k = 0; k < N; k++)
            repeat ($urandom_range(2)) jobs[k].push_back(rand_str());
         run(3000, 1'b0, "rand");
      end

`ifdef EXPR_ARB_TIMEOUT_EN
      jobs[0].push_back("1+!");                               run(300, 1'b0, "t7");
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
